// File: rtl/turn_scheduler_pkg.sv
// Shared types and constants for the turn scheduler of the cat-vs-dog
// artillery game: FSM state encoding, game tuning values and player codes.
package turn_scheduler_pkg;

  typedef enum logic [2:0] {IDLE, AIM, CHARGE, FLIGHT, RESOLVE, OVER} turn_state_t;

  localparam int HP_MAX         = 100;
  localparam int DAMAGE         = 25;
  localparam int POWER_MAX      = 200;
  localparam int POWER_STEP     = 2;
  localparam int FLIGHT_TIMEOUT = 240;
  localparam int WIND_MAX       = 15;

  localparam logic [1:0] PLAYER_NONE = 2'd0;
  localparam logic [1:0] PLAYER_1    = 2'd1;  // cat
  localparam logic [1:0] PLAYER_2    = 2'd2;  // dog

  // The player who is not p; only meaningful while a game is running.
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PLAYER_1) ? PLAYER_2 : PLAYER_1;
  endfunction

  // Interpret 5 random bits as signed wind; the one value outside
  // -WIND_MAX..+WIND_MAX (-16) is folded to calm air.
  function automatic logic signed [4:0] fold_wind(input logic [4:0] raw);
    logic signed [4:0] w;
    w = signed'(raw);
    return (int'(w) < -WIND_MAX) ? 5'sd0 : w;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Signal bundle between the turn scheduler and its neighbours: debounced
// inputs and projectile handshake in, launch request and HUD values out.
// The scheduler uses the slave view; whoever drives the inputs uses master.
interface turn_scheduler_if;

  logic              frame_tick;
  logic              start;
  logic              fire1;
  logic              fire2;
  logic              proj_done;
  logic              proj_hit;
  logic              launch;
  logic [7:0]        launch_power;
  logic [1:0]        active_player;
  logic [7:0]        power;
  logic [6:0]        hp1;
  logic [6:0]        hp2;
  logic signed [4:0] wind;
  logic              game_over;
  logic [1:0]        winner;

  modport master (
    output frame_tick, start, fire1, fire2, proj_done, proj_hit,
    input  launch, launch_power, active_player, power, hp1, hp2, wind,
           game_over, winner
  );

  modport slave (
    input  frame_tick, start, fire1, fire2, proj_done, proj_hit,
    output launch, launch_power, active_player, power, hp1, hp2, wind,
           game_over, winner
  );

endinterface

// File: rtl/turn_scheduler_wind_lfsr.sv
// Wind generator: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that free-runs
// every clock; on redraw_i its low five bits are folded to -15..+15 and held.
// Only built when WIND_EN is defined; otherwise the scheduler ties wind to 0.
`ifdef WIND_EN
module wind_lfsr
  import turn_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redraw_i,
  output logic signed [4:0] wind_o
);

  logic [7:0]        lfsr_q;
  logic [7:0]        lfsr_d;
  logic signed [4:0] wind_q;

  // Next LFSR value: shift left, feedback from taps 8, 6, 5, 4.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Step the LFSR every clock; latch a new wind value only on redraw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
      wind_q <= 5'sd0;
    end else begin
      lfsr_q <= lfsr_d;
      if (redraw_i) wind_q <= fold_wind(lfsr_q[4:0]);
    end
  end

  assign wind_o = wind_q;

endmodule
`endif

// File: rtl/turn_scheduler.sv
// Turn-sequencing controller: alternates the cat and the dog, charges shot
// power while the active fire button is held, issues a one-cycle launch,
// waits for the flight result, applies damage and declares the winner.
// Optional feature macro: WIND_EN (random wind per turn via wind_lfsr);
// without it wind is constant 0.
module turn_scheduler #(
  parameter int HP_MAX         = turn_scheduler_pkg::HP_MAX,
  parameter int DAMAGE         = turn_scheduler_pkg::DAMAGE,
  parameter int POWER_MAX      = turn_scheduler_pkg::POWER_MAX,
  parameter int POWER_STEP     = turn_scheduler_pkg::POWER_STEP,
  parameter int FLIGHT_TIMEOUT = turn_scheduler_pkg::FLIGHT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  turn_scheduler_if.slave   ctl
);

  import turn_scheduler_pkg::turn_state_t, turn_scheduler_pkg::IDLE,
         turn_scheduler_pkg::AIM, turn_scheduler_pkg::CHARGE,
         turn_scheduler_pkg::FLIGHT, turn_scheduler_pkg::RESOLVE,
         turn_scheduler_pkg::OVER;
  import turn_scheduler_pkg::PLAYER_NONE, turn_scheduler_pkg::PLAYER_1,
         turn_scheduler_pkg::PLAYER_2, turn_scheduler_pkg::other_player;

  localparam logic [6:0] HP_INIT      = 7'(HP_MAX);
  localparam logic [6:0] HP_DMG       = 7'(DAMAGE);
  localparam logic [7:0] PWR_MAX      = 8'(POWER_MAX);
  localparam logic [8:0] PWR_STEP     = 9'(POWER_STEP);
  localparam logic [7:0] FLIGHT_LIMIT = 8'(FLIGHT_TIMEOUT);

  turn_state_t state_q, state_d;
  logic        launch_q, launch_d;
  logic [7:0]  launch_power_q, launch_power_d;
  logic [1:0]  active_q, active_d;
  logic [7:0]  power_q, power_d;
  logic [6:0]  hp1_q, hp1_d;
  logic [6:0]  hp2_q, hp2_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        hit_q, hit_d;
  logic [1:0]  fire_prev_q;
  logic        redraw;

  logic        fire_now, fire_was, fire_rise, fire_fall;
  logic [8:0]  power_sum;
  logic [7:0]  power_sat;
  logic [7:0]  frame_cnt_inc;
  logic [6:0]  opp_hp, opp_hp_after;

  // Select the active player's fire level and its registered copy; the
  // inactive player's button never reaches the FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    fire_now = 1'b0;
    fire_was = 1'b0;
    if (active_q == PLAYER_1) begin
      fire_now = ctl.fire1;
      fire_was = fire_prev_q[0];
    end else if (active_q == PLAYER_2) begin
      fire_now = ctl.fire2;
      fire_was = fire_prev_q[1];
    end
  end

  assign fire_rise     = fire_now & ~fire_was;
  assign fire_fall     = ~fire_now & fire_was;
  assign power_sum     = {1'b0, power_q} + PWR_STEP;
  assign power_sat     = (power_sum > {1'b0, PWR_MAX}) ? PWR_MAX : power_sum[7:0];
  assign frame_cnt_inc = frame_cnt_q + 8'd1;
  assign opp_hp        = (active_q == PLAYER_1) ? hp2_q : hp1_q;
  assign opp_hp_after  = !hit_q            ? opp_hp :
                         (opp_hp > HP_DMG) ? opp_hp - HP_DMG : 7'd0;

  // Next-state and next-register logic for the turn FSM.
  always_comb begin
    state_d        = state_q;
    launch_d       = 1'b0;
    launch_power_d = launch_power_q;
    active_d       = active_q;
    power_d        = power_q;
    hp1_d          = hp1_q;
    hp2_d          = hp2_q;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    frame_cnt_d    = frame_cnt_q;
    hit_d          = hit_q;
    redraw         = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (ctl.start) begin
          hp1_d       = HP_INIT;
          hp2_d       = HP_INIT;
          active_d    = PLAYER_1;
          power_d     = 8'd0;
          game_over_d = 1'b0;
          winner_d    = PLAYER_NONE;
          redraw      = 1'b1;
          state_d     = AIM;
        end
      end
      AIM: begin
        if (fire_rise) begin
          power_d = 8'd0;
          state_d = CHARGE;
        end
      end
      CHARGE: begin
        // Release beats a coincident frame tick: launch the current power.
        if (fire_fall) begin
          launch_d       = 1'b1;
          launch_power_d = power_q;
          power_d        = 8'd0;
          frame_cnt_d    = 8'd0;
          state_d        = FLIGHT;
        end else if (ctl.frame_tick) begin
          power_d = power_sat;
        end
      end
      FLIGHT: begin
        // A real result beats a coincident timeout.
        if (ctl.proj_done) begin
          hit_d   = ctl.proj_hit;
          state_d = RESOLVE;
        end else if (ctl.frame_tick) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == FLIGHT_LIMIT) begin
            hit_d   = 1'b0;
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        if (active_q == PLAYER_1) hp2_d = opp_hp_after;
        else                      hp1_d = opp_hp_after;
        if (opp_hp_after == 7'd0) begin
          winner_d    = active_q;
          active_d    = PLAYER_NONE;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          active_d = other_player(active_q);
          redraw   = 1'b1;
          state_d  = AIM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; fire history is sampled in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      launch_q       <= 1'b0;
      launch_power_q <= 8'd0;
      active_q       <= PLAYER_NONE;
      power_q        <= 8'd0;
      hp1_q          <= HP_INIT;
      hp2_q          <= HP_INIT;
      game_over_q    <= 1'b0;
      winner_q       <= PLAYER_NONE;
      frame_cnt_q    <= 8'd0;
      hit_q          <= 1'b0;
      fire_prev_q    <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values regardless of statement order.
      state_q        <= state_d;
      launch_q       <= launch_d;
      launch_power_q <= launch_power_d;
      active_q       <= active_d;
      power_q        <= power_d;
      hp1_q          <= hp1_d;
      hp2_q          <= hp2_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
      frame_cnt_q    <= frame_cnt_d;
      hit_q          <= hit_d;
      fire_prev_q    <= {ctl.fire2, ctl.fire1};
    end
  end

`ifdef WIND_EN
  wind_lfsr u_wind (
    .clk      (clk),
    .rst_n    (rst_n),
    .redraw_i (redraw),
    .wind_o   (ctl.wind)
  );
`else
  logic unused_redraw;
  assign unused_redraw = redraw;
  assign ctl.wind      = 5'sd0;
`endif

  assign ctl.launch        = launch_q;
  assign ctl.launch_power  = launch_power_q;
  assign ctl.active_player = active_q;
  assign ctl.power         = power_q;
  assign ctl.hp1           = hp1_q;
  assign ctl.hp2           = hp2_q;
  assign ctl.game_over     = game_over_q;
  assign ctl.winner        = winner_q;

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Turn-sequencing controller for the cat-vs-dog artillery game. It alternates control between PLAYER_1 (cat) and PLAYER_2 (dog) and accumulates shot power while the active player's fire button is held. It issues a one-cycle launch request to the projectile datapath, waits for the flight result, applies damage to HP, redraws wind and declares the winner. The block sits between the debounced input logic and the projectile/draw modules, and feeds the HP, power and wind bar renderers.

## Interface
Parameters:
- HP_MAX, 100: starting HP per player (7-bit)
- DAMAGE, 25: HP removed per hit
- POWER_MAX, 200: power saturation value (8-bit)
- POWER_STEP, 2: power increment per frame tick while charging
- FLIGHT_TIMEOUT, 240: frames allowed in flight before the shot is forced to a miss

Ports:
- clk  in  1  system clock (60 MHz pixel clock domain)
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse; starts or restarts a game
- fire1, fire2  in  1  debounced, synchronous fire levels (1 = held)
- proj_done  in  1  one-cycle pulse from the projectile datapath; flight finished
- proj_hit  in  1  qualified by proj_done; 1 = opponent hit
- launch  out  1  one-cycle launch request
- launch_power  out  8  power latched at launch; stable until the next launch
- active_player  out  2  0 = none, 1 = PLAYER_1, 2 = PLAYER_2
- power  out  8  live power bar value
- hp1, hp2  out  7  current HP
- wind  out  5  signed wind, range -15..+15
- game_over  out  1  level, high in OVER
- winner  out  2  0, PLAYER_1 or PLAYER_2

## Operation
- States: IDLE, AIM, CHARGE, FLIGHT, RESOLVE, OVER.
- IDLE: on start, go to AIM. Set hp1 = hp2 = HP_MAX and active_player = PLAYER_1, and draw a new wind.
- AIM: a rising edge of the active player's fire goes to CHARGE with power = 0. The inactive player's fire is ignored in every state.
- CHARGE: on each frame_tick, power += POWER_STEP, saturating at POWER_MAX.
  - On the falling edge of the active fire: launch_power = power, launch = 1 for one cycle, power = 0, frame counter = 0, go to FLIGHT.
- FLIGHT: the counter increments on frame_tick. proj_done records hit = proj_hit. Reaching FLIGHT_TIMEOUT frames records hit = 0. Either event goes to RESOLVE.
- RESOLVE (single cycle):
  - If hit, the opponent's HP -= DAMAGE, saturating at 0.
  - If the opponent's HP becomes 0: winner = active player, go to OVER.
  - Otherwise: swap active_player, draw a new wind, go to AIM.
- OVER: active_player = 0; on start, same action as from IDLE.
- Edge detection uses a registered copy of fire1/fire2. The registered copy is updated in every state.
- Wind: an 8-bit LFSR (x^8+x^6+x^5+x^4+1) steps every clk. wind = lfsr[4:0] folded to -15..+15; the value -16 maps to 0.

## Timing
- Reset values: state IDLE, launch 0, launch_power 0, active_player 0, power 0, hp1 = hp2 = HP_MAX, wind 0, game_over 0, winner 0, LFSR = 8'hA5.
- All outputs are registered.
- Fire release seen at cycle N: launch is high at N+1.
- proj_done at cycle N: RESOLVE at N+1; HP, active_player and wind update at N+2.
- frame_tick and fire release in the same cycle: the release wins and launch_power takes the un-incremented value.
- proj_done and timeout in the same cycle: proj_done wins.
- proj_done outside FLIGHT is ignored. start outside IDLE/OVER is ignored.
- Fire held when entering AIM does not start a charge; a fresh rising edge is required.
- rst_n low mid-flight aborts immediately to the reset values. No pending launch survives reset.

## Configuration
- WIND_EN defined: wind is redrawn from the LFSR at game start and at each turn swap.
- WIND_EN undefined: the LFSR is not instantiated and wind is constant 0.

## Structure
- Add to variable_pkg:
  - typedef enum logic [2:0] turn_state_t {IDLE, AIM, CHARGE, FLIGHT, RESOLVE, OVER}
  - constants HP_MAX, DAMAGE, POWER_MAX, POWER_STEP, FLIGHT_TIMEOUT, WIND_MAX = 15
- Reuse PLAYER_1/PLAYER_2 from the package.
- One sub-module: wind_lfsr (LFSR plus fold to signed 5-bit; enable input drives the redraw). Instantiated only under WIND_EN.

## Test plan
- Reset, then start: hp1 = hp2 = 100, active_player = 1, power = 0, launch = 0.
- fire1 held 50 frame ticks, then released: power reaches 100; exactly one launch pulse one cycle after release; launch_power = 100.
- fire1 held 150 frames: power saturates at 200, launch_power = 200. fire2 pulses during the charge have no effect.
- proj_done with proj_hit = 1 four times on alternating turns by PLAYER_1: hp2 steps 75 → 50 → 25 → 0, game_over = 1, winner = 1. A later start restores HP to 100.
- No proj_done for 240 frames: forced miss, HPs unchanged, active_player toggles to 2.
- rst_n asserted mid-FLIGHT: outputs at reset values asynchronously. With WIND_EN undefined, wind stays 0 across 10 turns.
